// File: rtl/jelly2_img_filter2d_window.sv
// Raster-to-window stage for the 2D filter: (ROWS-1) line memories plus a column shift register.
// Define JELLY2_IMG_FILTER2D_WINDOW_REPLICATE_EN to replicate edge pixels instead of using a constant border.
module jelly2_img_filter2d_window #(
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_COLS   = 1024
) (
  input  logic                                reset,
  input  logic                                clk,
  input  logic                                cke,
  input  logic [DATA_WIDTH-1:0]               param_border_value,
  input  logic                                s_img_row_first,
  input  logic                                s_img_row_last,
  input  logic                                s_img_col_first,
  input  logic                                s_img_col_last,
  input  logic [DATA_WIDTH-1:0]               s_img_data,
  input  logic                                s_img_valid,
  output logic                                m_img_row_first,
  output logic                                m_img_row_last,
  output logic                                m_img_col_first,
  output logic                                m_img_col_last,
  output logic [ROWS*COLS*DATA_WIDTH-1:0]     m_img_data,
  output logic                                m_img_valid
);

  localparam int CW     = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int RW     = $clog2(ROWS + 1);
  localparam int WIN_W  = ROWS * COLS * DATA_WIDTH;
  localparam int COLV_W = ROWS * DATA_WIDTH;

  // Element (i,j) of a window lives at bit ((i*COLS)+j)*DATA_WIDTH; (ROWS-1,COLS-1) is the newest pixel.
  function automatic logic [WIN_W-1:0] border_fill(
    input logic [WIN_W-1:0]      win,
    input logic [ROWS-1:0]       rmask,
    input logic [COLS-1:0]       cmask,
    input logic [DATA_WIDTH-1:0] bval
  );
    logic [WIN_W-1:0] w;
    w = win;
`ifdef JELLY2_IMG_FILTER2D_WINDOW_REPLICATE_EN
    for (int i = ROWS - 2; i >= 0; i--) begin
      if (rmask[i]) begin
        for (int j = 0; j < COLS; j++) begin
          w[((i*COLS)+j)*DATA_WIDTH +: DATA_WIDTH] = w[(((i+1)*COLS)+j)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    for (int j = COLS - 2; j >= 0; j--) begin
      if (cmask[j]) begin
        for (int i = 0; i < ROWS; i++) begin
          w[((i*COLS)+j)*DATA_WIDTH +: DATA_WIDTH] = w[((i*COLS)+j+1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
`else
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (rmask[i] || cmask[j]) begin
          w[((i*COLS)+j)*DATA_WIDTH +: DATA_WIDTH] = bval;
        end
      end
    end
`endif
    return w;
  endfunction

  logic [CW-1:0]     r_col;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     r_rows_avail;
  logic [RW-1:0]     w_rows_avail;
  logic [COLV_W-1:0] w_colvec;
  logic [ROWS-1:0]   w_row_mask;
  logic [COLS-1:0]   w_col_mask;

  // A first-of-row / first-of-frame pixel sees its counters already cleared.
  assign w_col        = s_img_col_first ? '0 : r_col;
  assign w_rows_avail = (s_img_row_first && s_img_col_first) ? '0 : r_rows_avail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col        <= '0;
      r_rows_avail <= '0;
    end else if (cke && s_img_valid) begin
      r_col <= (w_col == CW'(MAX_COLS - 1)) ? w_col : w_col + CW'(1);
      if (s_img_col_last && (w_rows_avail != RW'(ROWS - 1))) begin
        r_rows_avail <= w_rows_avail + RW'(1);
      end else begin
        r_rows_avail <= w_rows_avail;
      end
    end
  end

  generate
    if (ROWS > 1) begin : g_linemem
      logic [DATA_WIDTH-1:0] r_mem [ROWS-1][MAX_COLS];

      // Read-before-write: each memory passes its old entry down to the next one.
      always_ff @(posedge clk) begin
        if (cke && s_img_valid) begin
          r_mem[0][w_col] <= s_img_data;
          for (int k = 1; k < ROWS - 1; k++) begin
            r_mem[k][w_col] <= r_mem[k-1][w_col];
          end
        end
      end

      for (genvar k = 0; k < ROWS - 1; k++) begin : g_rd
        assign w_colvec[(ROWS-2-k)*DATA_WIDTH +: DATA_WIDTH] = r_mem[k][w_col];
      end
    end
  endgenerate

  assign w_colvec[(ROWS-1)*DATA_WIDTH +: DATA_WIDTH] = s_img_data;

  always_comb begin
    int v_col_min;
    w_row_mask = '0;
    w_col_mask = '0;
    v_col_min  = (int'(w_col) > COLS - 1) ? COLS - 1 : int'(w_col);
    for (int i = 0; i < ROWS; i++) begin
      w_row_mask[i] = (i < (ROWS - 1 - int'(w_rows_avail)));
    end
    for (int j = 0; j < COLS; j++) begin
      w_col_mask[j] = (j < (COLS - 1 - v_col_min));
    end
  end

  // ---- stage 1: line-memory read, border masks ----
  logic              r_vld_p1;
  logic [3:0]        r_flg_p1;
  logic [COLV_W-1:0] r_colvec_p1;
  logic [ROWS-1:0]   r_row_mask_p1;
  logic [COLS-1:0]   r_col_mask_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_flg_p1 <= '0;
    end else if (cke) begin
      r_vld_p1 <= s_img_valid;
      r_flg_p1 <= s_img_valid ? {s_img_row_first, s_img_row_last, s_img_col_first, s_img_col_last} : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (cke && s_img_valid) begin
      r_colvec_p1   <= w_colvec;
      r_row_mask_p1 <= w_row_mask;
      r_col_mask_p1 <= w_col_mask;
    end
  end

  // ---- stage 2: column shift register, border fill, output register ----
  logic [WIN_W-1:0] r_win_p2;
  logic [WIN_W-1:0] w_win_next;

  always_comb begin
    w_win_next = r_win_p2;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS - 1; j++) begin
        w_win_next[((i*COLS)+j)*DATA_WIDTH +: DATA_WIDTH] = r_win_p2[((i*COLS)+j+1)*DATA_WIDTH +: DATA_WIDTH];
      end
      w_win_next[((i*COLS)+COLS-1)*DATA_WIDTH +: DATA_WIDTH] = r_colvec_p1[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (cke && r_vld_p1) begin
      r_win_p2 <= w_win_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_img_valid     <= 1'b0;
      m_img_row_first <= 1'b0;
      m_img_row_last  <= 1'b0;
      m_img_col_first <= 1'b0;
      m_img_col_last  <= 1'b0;
      m_img_data      <= '0;
    end else if (cke) begin
      m_img_valid <= r_vld_p1;
      {m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last} <= r_flg_p1;
      if (r_vld_p1) begin
        m_img_data <= border_fill(w_win_next, r_row_mask_p1, r_col_mask_p1, param_border_value);
      end
    end
  end

endmodule
